// File: rtl/acc_drain_pkg.sv
// Shared definitions for the saturating down-accumulator: read-port states and
// command priority encoding.
package acc_drain_pkg;

    localparam logic RD_IDLE = 1'b0;
    localparam logic RD_FULL = 1'b1;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_DEC,
        CMD_SUB,
        CMD_LOAD,
        CMD_CLR
    } cmd_e;

    // Clear beats load beats subtract beats decrement.
    function automatic cmd_e cmd_decode(input logic clr, input logic load,
                                        input logic sub, input logic dec);
        if (clr) begin
            return CMD_CLR;
        end else if (load) begin
            return CMD_LOAD;
        end else if (sub) begin
            return CMD_SUB;
        end else if (dec) begin
            return CMD_DEC;
        end
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/acc_drain_rdport.sv
// Snapshot read port: one-entry valid/ready holding register with drop detection.
module acc_drain_rdport
    import acc_drain_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] acc_i,
    input  logic         rd_stb_i,
    input  logic         rd_ready_i,
    output logic         rd_valid_o,
    output logic [W-1:0] rd_data_o,
    output logic         rd_drop_o
);

    logic         state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        drop_d  = 1'b0;
        if (state_q == RD_IDLE) begin
            if (rd_stb_i) begin
                data_d  = acc_i;
                state_d = RD_FULL;
            end
        end else begin
            if (rd_ready_i) begin
                if (rd_stb_i) begin
                    data_d = acc_i;
                end else begin
                    state_d = RD_IDLE;
                end
            end else if (rd_stb_i) begin
                // Holding an unread snapshot: the new request is lost.
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RD_IDLE;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign rd_valid_o = (state_q == RD_FULL);
    assign rd_data_o  = data_q;
    assign rd_drop_o  = drop_q;

endmodule

// File: rtl/acc_drain.sv
// Saturating down-accumulator with borrow flag and a registered snapshot read port.
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_dec,
    input  logic         i_sub,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_acc,
    output logic         o_empty,
    output logic         o_borrow,
    input  logic         i_rd_stb,
    output logic         o_rd_valid,
    input  logic         i_rd_ready,
    output logic [W-1:0] o_rd_data,
    output logic         o_rd_drop
);

    logic [W-1:0] acc_q, acc_d;
    logic         borrow_q, borrow_d;
    cmd_e         cmd;

    always_comb begin
        cmd      = cmd_decode(i_clr, i_load, i_sub, i_dec);
        acc_d    = acc_q;
        borrow_d = 1'b0;
        case (cmd)
            CMD_CLR:  acc_d = '0;
            CMD_LOAD: acc_d = i_val;
            CMD_SUB: begin
                if (i_val > acc_q) begin
                    acc_d    = '0;
                    borrow_d = 1'b1;
                end else begin
                    acc_d = acc_q - i_val;
                end
            end
            CMD_DEC: begin
                if (acc_q == '0) begin
                    borrow_d = 1'b1;
                end else begin
                    acc_d = acc_q - W'(1);
                end
            end
            default: acc_d = acc_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            borrow_q <= borrow_d;
        end
    end

    assign o_acc    = acc_q;
    assign o_empty  = (acc_q == '0);
    assign o_borrow = borrow_q;

    // Snapshot sees the registered count, i.e. the pre-update value of any edge.
    acc_drain_rdport #(
        .W(W)
    ) u_rdport (
        .clk_i      (i_clk),
        .rst_ni     (i_reset_n),
        .acc_i      (acc_q),
        .rd_stb_i   (i_rd_stb),
        .rd_ready_i (i_rd_ready),
        .rd_valid_o (o_rd_valid),
        .rd_data_o  (o_rd_data),
        .rd_drop_o  (o_rd_drop)
    );

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: commands, saturation, priority and the snapshot port.
module tb_acc_drain;

    localparam int unsigned W = 16;

    logic         i_clk;
    logic         i_reset_n;
    logic         i_dec, i_sub, i_clr, i_load;
    logic [W-1:0] i_val;
    logic [W-1:0] o_acc;
    logic         o_empty, o_borrow;
    logic         i_rd_stb, i_rd_ready;
    logic         o_rd_valid, o_rd_drop;
    logic [W-1:0] o_rd_data;

    int errors = 0;
    int checks = 0;

    acc_drain #(
        .W(W)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_dec      (i_dec),
        .i_sub      (i_sub),
        .i_clr      (i_clr),
        .i_load     (i_load),
        .i_val      (i_val),
        .o_acc      (o_acc),
        .o_empty    (o_empty),
        .o_borrow   (o_borrow),
        .i_rd_stb   (i_rd_stb),
        .o_rd_valid (o_rd_valid),
        .i_rd_ready (i_rd_ready),
        .o_rd_data  (o_rd_data),
        .o_rd_drop  (o_rd_drop)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_dec = 1'b0; i_sub = 1'b0; i_clr = 1'b0; i_load = 1'b0;
        i_val = '0; i_rd_stb = 1'b0; i_rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b1;
        idle_inputs();
        i_load = 1'b1; i_val = 16'h1234;
        tick();
        idle_inputs();
        checks++; if (o_acc !== 16'h1234) begin errors++; $display("FAIL pre_reset_acc: got %h expected %h", o_acc, 16'h1234); end
        #2 i_reset_n = 1'b0;
        #1;
        checks++; if (o_acc !== 16'h0) begin errors++; $display("FAIL reset_acc: got %h expected 0000", o_acc); end
        checks++; if (o_borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", o_borrow); end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", o_rd_valid); end
        checks++; if (o_rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", o_rd_data); end
        checks++; if (o_rd_drop !== 1'b0) begin errors++; $display("FAIL reset_rd_drop: got %b expected 0", o_rd_drop); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    task automatic test_load_dec();
        logic [W-1:0] exp_acc [6] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
        i_load = 1'b1; i_val = 16'd5;
        tick();
        i_load = 1'b0;
        checks++; if (o_acc !== 16'd5) begin errors++; $display("FAIL load5_acc: got %0d expected 5", o_acc); end
        checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL load5_empty: got %b expected 0", o_empty); end
        i_dec = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (o_acc !== exp_acc[i]) begin errors++; $display("FAIL dec%0d_acc: got %0d expected %0d", i + 1, o_acc, exp_acc[i]); end
            checks++; if (o_borrow !== (i == 5)) begin errors++; $display("FAIL dec%0d_borrow: got %b expected %b", i + 1, o_borrow, (i == 5)); end
            checks++; if (o_empty !== (exp_acc[i] == 0)) begin errors++; $display("FAIL dec%0d_empty: got %b expected %b", i + 1, o_empty, (exp_acc[i] == 0)); end
        end
        i_dec = 1'b0;
        tick();
        checks++; if (o_borrow !== 1'b0) begin errors++; $display("FAIL dec_borrow_clear: got %b expected 0", o_borrow); end
    endtask

    task automatic test_sub();
        i_load = 1'b1; i_val = 16'd100;
        tick();
        i_load = 1'b0;
        i_sub = 1'b1; i_val = 16'd30;
        tick();
        checks++; if (o_acc !== 16'd70) begin errors++; $display("FAIL sub30_acc: got %0d expected 70", o_acc); end
        checks++; if (o_borrow !== 1'b0) begin errors++; $display("FAIL sub30_borrow: got %b expected 0", o_borrow); end
        i_val = 16'd71;
        tick();
        checks++; if (o_acc !== 16'd0) begin errors++; $display("FAIL sub71_acc: got %0d expected 0", o_acc); end
        checks++; if (o_borrow !== 1'b1) begin errors++; $display("FAIL sub71_borrow: got %b expected 1", o_borrow); end
        i_val = 16'd0;
        tick();
        checks++; if (o_acc !== 16'd0) begin errors++; $display("FAIL sub0_acc: got %0d expected 0", o_acc); end
        checks++; if (o_borrow !== 1'b0) begin errors++; $display("FAIL sub0_borrow: got %b expected 0", o_borrow); end
        // Exact-match subtraction reaches zero without a borrow.
        i_sub = 1'b0; i_load = 1'b1; i_val = 16'hFFFF;
        tick();
        i_load = 1'b0; i_sub = 1'b1;
        tick();
        i_sub = 1'b0;
        checks++; if (o_acc !== 16'd0) begin errors++; $display("FAIL subeq_acc: got %h expected 0000", o_acc); end
        checks++; if (o_borrow !== 1'b0) begin errors++; $display("FAIL subeq_borrow: got %b expected 0", o_borrow); end
    endtask

    task automatic test_priority();
        i_load = 1'b1; i_val = 16'd50;
        tick();
        i_clr = 1'b1; i_load = 1'b1; i_sub = 1'b1; i_dec = 1'b1; i_val = 16'd9;
        tick();
        checks++; if (o_acc !== 16'd0) begin errors++; $display("FAIL prio_clr_acc: got %0d expected 0", o_acc); end
        checks++; if (o_borrow !== 1'b0) begin errors++; $display("FAIL prio_clr_borrow: got %b expected 0", o_borrow); end
        i_clr = 1'b0;
        tick();
        checks++; if (o_acc !== 16'd9) begin errors++; $display("FAIL prio_load_acc: got %0d expected 9", o_acc); end
        checks++; if (o_borrow !== 1'b0) begin errors++; $display("FAIL prio_load_borrow: got %b expected 0", o_borrow); end
        i_load = 1'b0; i_val = 16'd4;
        tick();
        checks++; if (o_acc !== 16'd5) begin errors++; $display("FAIL prio_sub_acc: got %0d expected 5", o_acc); end
        idle_inputs();
    endtask

    task automatic test_snapshot_race();
        i_load = 1'b1; i_val = 16'd40;
        tick();
        i_load = 1'b0;
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL race_pre_valid: got %b expected 0", o_rd_valid); end
        i_rd_stb = 1'b1; i_sub = 1'b1; i_val = 16'd10;
        tick();
        idle_inputs();
        checks++; if (o_rd_data !== 16'd40) begin errors++; $display("FAIL race_rd_data: got %0d expected 40", o_rd_data); end
        checks++; if (o_acc !== 16'd30) begin errors++; $display("FAIL race_acc: got %0d expected 30", o_acc); end
        checks++; if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL race_valid: got %b expected 1", o_rd_valid); end
        i_rd_ready = 1'b1;
        tick();
        i_rd_ready = 1'b0;
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL race_drain_valid: got %b expected 0", o_rd_valid); end
        checks++; if (o_rd_data !== 16'd40) begin errors++; $display("FAIL race_drain_data: got %0d expected 40", o_rd_data); end
    endtask

    task automatic test_backpressure();
        // acc = 30 here; capture it and load 77 on the same edge.
        i_rd_stb = 1'b1; i_load = 1'b1; i_val = 16'd77;
        tick();
        i_load = 1'b0;
        checks++; if (o_rd_data !== 16'd30) begin errors++; $display("FAIL bp_first_data: got %0d expected 30", o_rd_data); end
        checks++; if (o_rd_drop !== 1'b0) begin errors++; $display("FAIL bp_first_drop: got %b expected 0", o_rd_drop); end
        tick();
        i_rd_stb = 1'b0;
        checks++; if (o_rd_drop !== 1'b1) begin errors++; $display("FAIL bp_drop: got %b expected 1", o_rd_drop); end
        checks++; if (o_rd_data !== 16'd30) begin errors++; $display("FAIL bp_drop_data: got %0d expected 30", o_rd_data); end
        checks++; if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL bp_drop_valid: got %b expected 1", o_rd_valid); end
        tick();
        checks++; if (o_rd_drop !== 1'b0) begin errors++; $display("FAIL bp_drop_pulse: got %b expected 0", o_rd_drop); end
        i_rd_stb = 1'b1; i_rd_ready = 1'b1;
        tick();
        checks++; if (o_rd_data !== 16'd77) begin errors++; $display("FAIL bp_recapture_data: got %0d expected 77", o_rd_data); end
        checks++; if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL bp_recapture_valid: got %b expected 1", o_rd_valid); end
        checks++; if (o_rd_drop !== 1'b0) begin errors++; $display("FAIL bp_recapture_drop: got %b expected 0", o_rd_drop); end
        i_rd_stb = 1'b0;
        tick();
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", o_rd_valid); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_data [3] = '{16'd77, 16'd76, 16'd75};
        i_rd_stb = 1'b1; i_rd_ready = 1'b1; i_dec = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_rd_data !== exp_data[i]) begin errors++; $display("FAIL b2b%0d_data: got %0d expected %0d", i, o_rd_data, exp_data[i]); end
            checks++; if (o_rd_drop !== 1'b0) begin errors++; $display("FAIL b2b%0d_drop: got %b expected 0", i, o_rd_drop); end
        end
        idle_inputs();
        checks++; if (o_acc !== 16'd74) begin errors++; $display("FAIL b2b_acc: got %0d expected 74", o_acc); end
        i_rd_ready = 1'b1;
        tick();
        i_rd_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        i_load = 1'b1; i_val = 16'hFFFF;
        tick();
        i_load = 1'b0; i_rd_stb = 1'b1;
        tick();
        i_rd_stb = 1'b0;
        checks++; if (o_rd_data !== 16'hFFFF) begin errors++; $display("FAIL ar_pre_data: got %h expected ffff", o_rd_data); end
        checks++; if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", o_rd_valid); end
        #2 i_reset_n = 1'b0;
        #1;
        checks++; if (o_acc !== 16'h0) begin errors++; $display("FAIL ar_acc: got %h expected 0000", o_acc); end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", o_rd_valid); end
        checks++; if (o_rd_data !== 16'h0) begin errors++; $display("FAIL ar_data: got %h expected 0000", o_rd_data); end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_load = 1'b1; i_val = 16'd3;
        tick();
        idle_inputs();
        checks++; if (o_acc !== 16'd3) begin errors++; $display("FAIL ar_first_edge_acc: got %0d expected 3", o_acc); end
        checks++; if (o_rd_drop !== 1'b0) begin errors++; $display("FAIL ar_no_drop: got %b expected 0", o_rd_drop); end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL ar_post_valid: got %b expected 0", o_rd_valid); end
    endtask

    initial begin
        test_reset();
        test_load_dec();
        test_sub();
        test_priority();
        test_snapshot_race();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
